mux_if: RTL and testbench
=========================

# mux_if

Parameterized 8-to-1 multiplexer for 4-bit data words in the combinational data-routing library. It selects one of eight equal-width inputs by a 3-bit select code using a prioritized if/else-if decode. The selected word is driven combinationally on `o`. A registered copy of the output and of the select code is also provided for downstream synchronous consumers.

## Interface
- `width`, default 4: data width of every input and of `o`/`o_q`.
- `swidth`, default 3: select width; the block is only defined for `swidth` = 3, which covers eight inputs.
- `clk`  input  1: single clock for the registered outputs.
- `rst`  input  1: reset, asynchronous and active-high; clears the registered outputs.
- `i0`..`i7`  input  `width` each: data inputs 0..7.
- `sel`  input  `swidth`: select code.
- `o`  output  `width`: combinational selected data.
- `o_q`  output  `width`: `o` registered on the rising edge of `clk`.
- `sel_q`  output  `swidth`: `sel` registered on the rising edge of `clk`, aligned with `o_q`.

## Operation
- Decode is a single if/else-if chain evaluated in this order:
  - `sel`==0 → `i0`
  - `sel`==1 → `i1`
  - continuing in order up to `sel`==7 → `i7`
  - final else → all zeros
- The final else branch is reachable only when `sel` contains X or Z in simulation. In that case `o` must be 0, not X and not `i7`.
- `o` depends only on `sel` and `i0`..`i7`.
  - No latch may be inferred; `o` must be assigned on every path.
  - `o` must not depend on `clk` or `rst`.
- Inputs that are not selected have no effect on `o`.
- Data passes through bit-exact, with no arithmetic or width conversion.
- `o_q` and `sel_q` hold the values of `o` and `sel` captured at the last rising edge of `clk`.

## Timing
- `o`: zero-cycle combinational path. It must settle within the same delta/timestep as any change on `sel` or on the selected input.
- `o_q` and `sel_q`: one-cycle latency. The values present before rising edge N appear after edge N.
- Reset behaviour:
  - While `rst`=1, `o_q`=0 and `sel_q`=0 immediately, without waiting for a clock edge.
  - Release of `rst` takes effect synchronously. The first capture happens at the first rising edge with `rst`=0.
- If `rst` is asserted mid-operation, the registers clear asynchronously. `o` is unaffected and keeps following its inputs.
- If inputs change simultaneously with a clock edge, `o_q` captures the pre-edge value of `o`.
- There is no handshake, enable or valid signal. Every clock edge captures.

## Test plan
- Walk all eight select codes, changing every input each step and holding each step for 30 time units:
  - Step 1: all inputs on pattern A,B,C,D; `sel`=0; `i0`=A → `o`=A.
  - Step 2: `sel`=1, `i1`=C → `o`=C.
  - Step 3: `sel`=2, `i2`=E → `o`=E.
  - Step 4: `sel`=3, `i3`=A → `o`=A.
- Continue the walk:
  - `sel`=4, `i4`=E → `o`=E.
  - `sel`=5, `i5`=A → `o`=A.
  - `sel`=6, `i6`=C → `o`=C.
  - `sel`=7, `i7`=E → `o`=E.
- Isolation check:
  - Setup: `sel`=2, `i2`=5.
  - Stimulus: toggle all other inputs through 0 and F.
  - Required: `o` stays 5.
- Unknown select: drive `sel`=3'bxxx → `o`=0.
- Registered path:
  - Stimulus: `rst`=1 for 2 cycles, then release; `sel`=6, `i6`=9.
  - Required: `o_q`=0 and `sel_q`=0 during reset; `o_q`=9 and `sel_q`=6 after the first rising edge following release.
- Asynchronous reset: assert `rst` between clock edges while `o_q`=9 → `o_q`=0 immediately, while `o` remains 9.

Source files
------------

// File: rtl/mux_if.sv
// 8-to-1 word mux with prioritized if/else-if decode plus registered copies of output and select.
// Latency: o is combinational, o_q/sel_q one cycle; no backpressure, every clock edge captures.
module mux_if #(
    parameter int width  = 4,
    parameter int swidth = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [width-1:0]  i0,
    input  logic [width-1:0]  i1,
    input  logic [width-1:0]  i2,
    input  logic [width-1:0]  i3,
    input  logic [width-1:0]  i4,
    input  logic [width-1:0]  i5,
    input  logic [width-1:0]  i6,
    input  logic [width-1:0]  i7,
    input  logic [swidth-1:0] sel,
    output logic [width-1:0]  o,
    output logic [width-1:0]  o_q,
    output logic [swidth-1:0] sel_q
);

    // An unknown select matches no branch and falls through to zero rather than i7.
    always_comb begin
        if (sel == swidth'(0))
            o = i0;
        else if (sel == swidth'(1))
            o = i1;
        else if (sel == swidth'(2))
            o = i2;
        else if (sel == swidth'(3))
            o = i3;
        else if (sel == swidth'(4))
            o = i4;
        else if (sel == swidth'(5))
            o = i5;
        else if (sel == swidth'(6))
            o = i6;
        else if (sel == swidth'(7))
            o = i7;
        else
            o = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q   <= '0;
            sel_q <= '0;
        end else begin
            o_q   <= o;
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_mux_if.sv
// Directed bench for mux_if: select walk, isolation, unknown select, registered path and async reset.
module tb_mux_if;

    logic       clk;
    logic       rst;
    logic [3:0] iv [8];
    logic [2:0] sel;
    logic [3:0] o;
    logic [3:0] o_q;
    logic [2:0] sel_q;

    int errors = 0;
    int checks = 0;

    mux_if #(.width(4), .swidth(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .i0    (iv[0]),
        .i1    (iv[1]),
        .i2    (iv[2]),
        .i3    (iv[3]),
        .i4    (iv[4]),
        .i5    (iv[5]),
        .i6    (iv[6]),
        .i7    (iv[7]),
        .sel   (sel),
        .o     (o),
        .o_q   (o_q),
        .sel_q (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected selected word per select code, hand-picked from the A/C/E walk.
    logic [3:0] walk_exp [8];
    logic [3:0] xexp;

    initial begin
        walk_exp[0] = 4'hA; walk_exp[1] = 4'hC; walk_exp[2] = 4'hE; walk_exp[3] = 4'hA;
        walk_exp[4] = 4'hE; walk_exp[5] = 4'hA; walk_exp[6] = 4'hC; walk_exp[7] = 4'hE;

        // Reset phase with sel=6, i6=9 already applied
        rst = 1'b1;
        sel = 3'd6;
        for (int j = 0; j < 8; j++) iv[j] = 4'(j + 1);
        iv[6] = 4'h9;
        #1;
        chk("reset_o_q_t0", {4'h0, o_q}, 8'h00);
        chk("reset_sel_q_t0", {5'h0, sel_q}, 8'h00);
        chk("reset_o_comb", {4'h0, o}, 8'h09);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o_q_held", {4'h0, o_q}, 8'h00);
        chk("reset_sel_q_held", {5'h0, sel_q}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_no_edge_o_q", {4'h0, o_q}, 8'h00);
        @(posedge clk);
        #1;
        chk("first_capture_o_q", {4'h0, o_q}, 8'h09);
        chk("first_capture_sel_q", {5'h0, sel_q}, 8'h06);

        // Asynchronous reset between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_o_q", {4'h0, o_q}, 8'h00);
        chk("async_rst_sel_q", {5'h0, sel_q}, 8'h00);
        chk("async_rst_o", {4'h0, o}, 8'h09);
        #2;
        rst = 1'b0;

        // Select walk: every input changes each step, non-selected inputs differ from the selected word
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sel = 3'(k);
            for (int j = 0; j < 8; j++)
                iv[j] = (j == k) ? walk_exp[k] : 4'(walk_exp[k] + 4'(j) + 4'd1);
            #1;
            chk($sformatf("walk_o_sel%0d", k), {4'h0, o}, {4'h0, walk_exp[k]});
            @(posedge clk);
            #1;
            chk($sformatf("walk_o_q_sel%0d", k), {4'h0, o_q}, {4'h0, walk_exp[k]});
            chk($sformatf("walk_sel_q_sel%0d", k), {5'h0, sel_q}, {5'h0, 3'(k)});
            #19;
        end

        // Isolation: non-selected inputs toggle, output stays on i2
        @(negedge clk);
        sel   = 3'd2;
        iv[2] = 4'h5;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 8; j++)
                if (j != 2) iv[j] = (p == 0) ? 4'h0 : 4'hF;
            #1;
            chk($sformatf("isolate_%0d", p), {4'h0, o}, 8'h05);
        end

        // Unknown select; a two-state simulator resolves X to some code, checked against the table
        for (int j = 0; j < 8; j++) iv[j] = 4'(4'h8 + 4'(j));
        sel = 3'bxxx;
        #1;
        xexp = $isunknown(sel) ? 4'h0 : iv[sel];
        chk("unknown_sel_o", {4'h0, o}, {4'h0, xexp});
        sel = 3'd0;
        #1;
        chk("after_unknown_o", {4'h0, o}, 8'h08);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
